// File: rtl/frame_buffer_write_ctrl_multipage_if.sv
// frame_buffer_write_ctrl_multipage_if: FIFO-pop and RAM-write bundle of the frame buffer write controller.
//   empty   : capture FIFO empty; head word and sof valid when low
//   sof     : head word is pixel 0 of a frame
//   rd_en   : FIFO pop (combinational in the controller)
//   wr      : write strobe for the popped word, one cycle after rd_en
//   addr_wr : pixel-granular write address, held while wr is low
//   master  : FIFO/RAM side, slave: controller side
interface frame_buffer_write_ctrl_multipage_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  empty;
   logic                  sof;
   logic                  rd_en;
   logic                  wr;
   logic [ADDR_WIDTH-1:0] addr_wr;
   modport master (output empty, sof, input rd_en, wr, addr_wr);
   modport slave  (input empty, sof, output rd_en, wr, addr_wr);
endinterface

// File: rtl/frame_buffer_write_ctrl_multipage.sv
// frame_buffer_write_ctrl_multipage: N-page frame buffer write controller with reader-page avoidance.
//   clk_i, resetn_i        : clock, asynchronous active-low reset
//   enable_i               : run; deassertion takes effect only at a frame boundary
//   resolution_width_i/_depth_i : active pixels per line / lines per frame
//   bus (slave)            : FIFO pop and write strobe/address bundle
//   rd_active_i, rd_page_i : reader is scanning rd_page_i
//   wr_page_o, last_page_o : page being written, most recently completed page
//   page_valid_o           : sticky, at least one page completed
//   frame_done_o, sof_err_o, frame_drop_o : single-cycle event pulses
module frame_buffer_write_ctrl_multipage #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_PAGES  = 3,
   parameter int PAGE_W     = 2
) (
   input  logic                 clk_i,
   input  logic                 resetn_i,
   input  logic                 enable_i,
   input  logic [15:0]          resolution_width_i,
   input  logic [15:0]          resolution_depth_i,
   input  logic                 rd_active_i,
   input  logic [PAGE_W-1:0]    rd_page_i,
   frame_buffer_write_ctrl_multipage_if.slave bus,
   output logic [PAGE_W-1:0]    wr_page_o,
   output logic [PAGE_W-1:0]    last_page_o,
   output logic                 page_valid_o,
   output logic                 frame_done_o,
   output logic                 sof_err_o,
   output logic                 frame_drop_o
);
   typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, FLIP} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   page_size_q, base_q, count_q, addr_q;
   logic [PAGE_W-1:0]       wr_page_q, last_page_q;
   logic                    wr_q, page_valid_q, frame_done_q, sof_err_q, frame_drop_q;
   logic [31:0]             product_d;
   logic [ADDR_WIDTH-1:0]   page_size_d, base_d;
   logic [PAGE_W-1:0]       cand_a_d, cand_d;
   logic                    pop_d, last_pix_d;

   function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] p);
      return (p == PAGE_W'(NUM_PAGES - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      product_d   = 32'(resolution_width_i) * 32'(resolution_depth_i);
      page_size_d = ADDR_WIDTH'(product_d);
      cand_a_d    = next_page(wr_page_q);
      // skip the page the reader holds; with two pages this can land back on our own page
      cand_d      = (rd_active_i && cand_a_d == rd_page_i) ? next_page(cand_a_d) : cand_a_d;
      base_d      = ADDR_WIDTH'(cand_d) * page_size_q;
      pop_d       = (state_q == WAIT_SOF) ? (enable_i && page_size_d != '0 && !bus.empty)
                                          : (state_q == WRITE && !bus.empty);
      last_pix_d  = count_q == page_size_q - ADDR_WIDTH'(1);
   end

   assign bus.rd_en    = pop_d;
   assign bus.wr       = wr_q;
   assign bus.addr_wr  = addr_q;
   assign wr_page_o    = wr_page_q;
   assign last_page_o  = last_page_q;
   assign page_valid_o = page_valid_q;
   assign frame_done_o = frame_done_q;
   assign sof_err_o    = sof_err_q;
   assign frame_drop_o = frame_drop_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q      <= IDLE;
         page_size_q  <= '0;
         base_q       <= '0;
         count_q      <= '0;
         addr_q       <= '0;
         wr_page_q    <= '0;
         last_page_q  <= '0;
         wr_q         <= 1'b0;
         page_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         frame_drop_q <= 1'b0;
      end else begin
         // pops while hunting for SOF are discarded, every other pop is written
         wr_q         <= pop_d && (state_q == WRITE || bus.sof);
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         frame_drop_q <= 1'b0;
         case (state_q)
            IDLE: if (enable_i) state_q <= WAIT_SOF;
            WAIT_SOF: begin
               page_size_q <= page_size_d;
               if (!enable_i) state_q <= IDLE;
               else if (pop_d && bus.sof) begin
                  addr_q  <= base_q;
                  count_q <= (page_size_d == ADDR_WIDTH'(1)) ? '0 : ADDR_WIDTH'(1);
                  state_q <= (page_size_d == ADDR_WIDTH'(1)) ? FLIP : WRITE;
               end
            end
            WRITE: if (pop_d) begin
               if (bus.sof && count_q != '0) begin
                  sof_err_q <= 1'b1;
                  addr_q    <= base_q;
                  count_q   <= ADDR_WIDTH'(1);
               end else begin
                  addr_q  <= base_q + count_q;
                  count_q <= last_pix_d ? '0 : count_q + ADDR_WIDTH'(1);
                  if (last_pix_d) state_q <= FLIP;
               end
            end
            FLIP: begin
               frame_done_q <= 1'b1;
               last_page_q  <= wr_page_q;
               page_valid_q <= 1'b1;
               frame_drop_q <= cand_d == wr_page_q;
               wr_page_q    <= cand_d;
               base_q       <= base_d;
               state_q      <= enable_i ? WAIT_SOF : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_buffer_write_ctrl_multipage.sv
// tb_frame_buffer_write_ctrl_multipage: checks a 3-page and a 2-page controller against a frame-level model.
module tb_frame_buffer_write_ctrl_multipage;
   localparam int AW = 32;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          enable = 1'b0;
   logic [15:0]   res_w = 16'd4, res_d = 16'd2;
   logic          rd_active = 1'b0;
   logic [PW-1:0] rd_page = '0;
   logic          empty, sof;
   logic [PW-1:0] wp3, lp3, wp2, lp2;
   logic          pv3, fd3, se3, dr3, pv2, fd2, se2, dr2;

   frame_buffer_write_ctrl_multipage_if #(.ADDR_WIDTH(AW)) bus3 ();
   frame_buffer_write_ctrl_multipage_if #(.ADDR_WIDTH(AW)) bus2 ();
   assign bus3.empty = empty;
   assign bus3.sof   = sof;
   assign bus2.empty = empty;
   assign bus2.sof   = sof;

   frame_buffer_write_ctrl_multipage #(.ADDR_WIDTH(AW), .NUM_PAGES(3), .PAGE_W(PW)) dut3 (
      .clk_i(clk), .resetn_i(resetn), .enable_i(enable),
      .resolution_width_i(res_w), .resolution_depth_i(res_d),
      .rd_active_i(rd_active), .rd_page_i(rd_page), .bus(bus3.slave),
      .wr_page_o(wp3), .last_page_o(lp3), .page_valid_o(pv3),
      .frame_done_o(fd3), .sof_err_o(se3), .frame_drop_o(dr3));

   frame_buffer_write_ctrl_multipage #(.ADDR_WIDTH(AW), .NUM_PAGES(2), .PAGE_W(PW)) dut2 (
      .clk_i(clk), .resetn_i(resetn), .enable_i(enable),
      .resolution_width_i(res_w), .resolution_depth_i(res_d),
      .rd_active_i(rd_active), .rd_page_i(rd_page), .bus(bus2.slave),
      .wr_page_o(wp2), .last_page_o(lp2), .page_valid_o(pv2),
      .frame_done_o(fd2), .sof_err_o(se2), .frame_drop_o(dr2));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int n_pop, n_wr, n_done, n_serr;
   bit fifo_q[$];
   bit rnd_stall = 1'b0;
   logic [31:0] ps_now;

   // frame-level reference: running / writing a frame / page turn pending, pixel index and per-page bases
   bit          m_run, m_frame, m_flip;
   int unsigned m_idx;
   logic [31:0] m_ps;
   int          m_page [2], m_last [2], m_valid [2];
   logic [31:0] m_base [2], e_addr [2];
   bit          e_wr, e_done, e_serr, e_rden;
   bit          e_drop [2];

   function automatic int npages(input int d);
      return (d == 0) ? 3 : 2;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      {m_run, m_frame, m_flip, e_wr, e_done, e_serr} = '0;
      m_idx = 0;
      m_ps  = '0;
      for (int d = 0; d < 2; d++) begin
         m_page[d] = 0; m_last[d] = 0; m_valid[d] = 0;
         m_base[d] = '0; e_addr[d] = '0; e_drop[d] = 1'b0;
      end
   endtask

   task automatic model_write(input int unsigned i);
      e_wr = 1'b1;
      for (int d = 0; d < 2; d++) e_addr[d] = m_base[d] + i;
   endtask

   task automatic model_edge();
      int cand;
      e_wr = 0; e_done = 0; e_serr = 0; e_drop[0] = 0; e_drop[1] = 0;
      if (!m_run) m_run = enable;
      else if (m_flip) begin
         m_flip = 0;
         e_done = 1;
         for (int d = 0; d < 2; d++) begin
            m_last[d]  = m_page[d];
            m_valid[d] = 1;
            cand = (m_page[d] + 1) % npages(d);
            if (rd_active && cand == int'(rd_page)) cand = (cand + 1) % npages(d);
            e_drop[d] = (cand == m_page[d]);
            m_page[d] = cand;
            m_base[d] = 32'(cand) * m_ps;
         end
         m_run = enable;
      end else if (!m_frame) begin
         m_ps = ps_now;
         if (!enable) m_run = 0;
         else if (e_rden && sof) begin
            model_write(0);
            if (m_ps == 32'd1) m_flip = 1;
            else begin m_frame = 1; m_idx = 1; end
         end
      end else if (e_rden) begin
         if (sof && m_idx != 0) begin
            e_serr = 1;
            model_write(0);
            m_idx = 1;
         end else begin
            model_write(m_idx);
            m_idx++;
            if (m_idx == m_ps) begin m_frame = 0; m_flip = 1; m_idx = 0; end
         end
      end
   endtask

   task automatic check_outputs();
      check("wr3", bus3.wr, e_wr);          check("addr3", bus3.addr_wr, e_addr[0]);
      check("wr_page3", wp3, m_page[0]);    check("last_page3", lp3, m_last[0]);
      check("page_valid3", pv3, m_valid[0]); check("frame_done3", fd3, e_done);
      check("sof_err3", se3, e_serr);       check("frame_drop3", dr3, e_drop[0]);
      check("wr2", bus2.wr, e_wr);          check("addr2", bus2.addr_wr, e_addr[1]);
      check("wr_page2", wp2, m_page[1]);    check("last_page2", lp2, m_last[1]);
      check("page_valid2", pv2, m_valid[1]); check("frame_done2", fd2, e_done);
      check("sof_err2", se2, e_serr);       check("frame_drop2", dr2, e_drop[1]);
   endtask

   // one clock: drive at negedge, check pop, advance model at posedge, check outputs at next negedge
   task automatic step();
      empty  = (rnd_stall && $urandom_range(0, 1) == 1) || fifo_q.size() == 0;
      sof    = (fifo_q.size() != 0) ? fifo_q[0] : 1'b0;
      ps_now = 32'(res_w) * 32'(res_d);
      #1;
      e_rden = m_run && !m_flip && !empty && (m_frame || (enable && ps_now != 0));
      check("rd_en3", bus3.rd_en, e_rden);
      check("rd_en2", bus2.rd_en, e_rden);
      if (bus3.rd_en) n_pop++;
      @(posedge clk);
      model_edge();
      if (e_rden) void'(fifo_q.pop_front());
      @(negedge clk);
      check_outputs();
      if (bus3.wr) n_wr++;
      if (fd3) n_done++;
      if (se3) n_serr++;
   endtask

   task automatic push_frame(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(i == 0);
   endtask

   task automatic drain(input int max_cycles);
      int c = 0;
      while ((fifo_q.size() != 0 || m_frame || m_flip) && c < max_cycles) begin step(); c++; end
      check("drain_in_budget", c < max_cycles, 1'b1);
      repeat (2) step();
   endtask

   task automatic apply_reset();
      #2 resetn = 1'b0;
      #1 model_reset();
      fifo_q.delete();
      check("rst_rd_en3", bus3.rd_en, 1'b0);
      check_outputs();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      {n_pop, n_wr, n_done, n_serr} = '0;
   endtask

   initial begin
      model_reset();
      empty = 1'b1; sof = 1'b0;
      @(negedge clk);
      apply_reset();

      // continuous 4x2 frames rotate through pages 0,1,2,0; resolution change inside the last frame is ignored
      enable = 1'b1;
      repeat (4) push_frame(8);
      for (int c = 0; c < 200 && (fifo_q.size() != 0 || m_frame || m_flip); c++) begin
         step();
         if (n_wr == 26) begin res_w = 16'd8; res_d = 16'd8; end
      end
      repeat (2) step();
      check("t1_writes", n_wr, 32);
      check("t1_done", n_done, 4);
      check("t1_valid", pv3, 1'b1);
      check("t1_page", wp3, 1);

      // reader holds page 1: 3-page skips to page 2, 2-page must reuse page 0
      res_w = 16'd4; res_d = 16'd2;
      apply_reset();
      rd_active = 1'b1; rd_page = 2'd1;
      push_frame(8);
      drain(100);
      check("t2_wr_page3", wp3, 2);
      check("t2_last_page3", lp3, 0);
      check("t3_wr_page2", wp2, 0);
      push_frame(8);
      drain(100);
      check("t23_done", n_done, 2);

      // junk before SOF is discarded, early SOF restarts the page
      apply_reset();
      rd_active = 1'b0;
      for (int i = 0; i < 3; i++) fifo_q.push_back(1'b0);
      push_frame(5);
      push_frame(8);
      drain(100);
      check("t4_discards", n_pop - n_wr, 3);
      check("t4_sof_err", n_serr, 1);
      check("t4_writes", n_wr, 13);

      // random stalls, reader activity and page choices
      apply_reset();
      rnd_stall = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         if (fifo_q.size() < 16) push_frame(8);
         rd_active = 1'($urandom_range(0, 1));
         rd_page   = PW'($urandom_range(0, 2));
         step();
      end
      rnd_stall = 1'b0;
      drain(400);
      check("t5_pop_eq_wr", n_pop, n_wr);
      check("t5_progress", n_wr > 200, 1'b1);

      // enable dropped mid-frame: frame completes, then controller idles
      apply_reset();
      rd_active = 1'b0;
      push_frame(8);
      repeat (5) step();
      enable = 1'b0;
      drain(100);
      check("t6_frame_finished", n_done, 1);
      push_frame(8);
      {n_pop, n_wr} = '0;
      repeat (10) step();
      check("t6_idle_no_pop", n_pop, 0);

      // reset in the middle of a page
      enable = 1'b1;
      apply_reset();
      push_frame(8);
      for (int c = 0; c < 50 && m_idx != 4; c++) step();
      check("t6_reached_count4", m_idx, 4);
      apply_reset();
      check("t6_rst_valid", pv3, 1'b0);
      push_frame(8);
      push_frame(8);
      drain(100);
      check("t6_restart_done", n_done, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
